// File: rtl/first_filter_table_loader_if.sv
// Config-command and table-write bus between the control plane and first_filter_table_loader.
// The slave modport is the loader's view; the master modport is the control plane's view.
interface first_filter_table_loader_if #(
    parameter int unsigned AWIDTH = 13,
    parameter int unsigned DWIDTH = 64
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_op;
    logic [31:0]       cfg_data;
    logic [DWIDTH-1:0] wr_data;
    logic [AWIDTH-1:0] wr_addr;
    logic              wr_en;

    modport master (
        output cfg_valid, cfg_op, cfg_data,
        input  cfg_ready, wr_data, wr_addr, wr_en
    );

    modport slave (
        input  cfg_valid, cfg_op, cfg_data,
        output cfg_ready, wr_data, wr_addr, wr_en
    );
endinterface

// File: rtl/first_filter_table_loader.sv
// Programming-side writer for the first-filter match tables: LO/HI word pairs become one
// 64-bit write at an auto-incrementing address; CLEAR fills every entry with INIT_VALUE.
// Optional write counter port wr_count is enabled by defining FF_LOADER_STATS_EN.
module first_filter_table_loader #(
    parameter int unsigned       AWIDTH     = 13,
    parameter int unsigned       DEPTH      = 8192,
    parameter int unsigned       DWIDTH     = 64,
    parameter logic [DWIDTH-1:0] INIT_VALUE = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    first_filter_table_loader_if.slave  bus,
    output logic                        busy,
    output logic                        clear_done,
    output logic                        seq_err
`ifdef FF_LOADER_STATS_EN
    ,
    output logic [31:0]                 wr_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_SET_ADDR = 2'd0,
        OP_DATA_LO  = 2'd1,
        OP_DATA_HI  = 2'd2,
        OP_CLEAR    = 2'd3
    } op_e;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [31:0]       lo_q, lo_d;
    logic              lo_valid_q, lo_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [DWIDTH-1:0] wr_data_q, wr_data_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic              busy_q, busy_d;
    logic              clear_done_q, clear_done_d;
    logic              seq_err_q, seq_err_d;

    logic              cfg_ready;
    logic              cmd_fire;
    op_e               cmd_op;

    // Ready is forced low by rst itself, so nothing is accepted during reset.
    assign cfg_ready = (state_q == ST_IDLE) && !rst;
    assign cmd_fire  = bus.cfg_valid && cfg_ready;
    assign cmd_op    = op_e'(bus.cfg_op);

    // NOTE: every *_d gets a default before the case below, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        addr_ptr_d   = addr_ptr_q;
        lo_d         = lo_q;
        lo_valid_d   = lo_valid_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        clear_done_d = 1'b0;
        seq_err_d    = seq_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    unique case (cmd_op)
                        OP_SET_ADDR: begin
                            addr_ptr_d = bus.cfg_data[AWIDTH-1:0];
                            lo_valid_d = 1'b0;
                        end
                        OP_DATA_LO: begin
                            lo_d       = bus.cfg_data;
                            lo_valid_d = 1'b1;
                        end
                        OP_DATA_HI: begin
                            if (lo_valid_q) begin
                                state_d    = ST_WRITE;
                                wr_en_d    = 1'b1;
                                wr_data_d  = DWIDTH'({bus.cfg_data, lo_q});
                                wr_addr_d  = addr_ptr_q;
                                addr_ptr_d = (addr_ptr_q == LAST_ADDR) ? '0
                                                                       : addr_ptr_q + AWIDTH'(1);
                                lo_valid_d = 1'b0;
                            end else begin
                                seq_err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            // First CLEAR write goes out in the first CLEAR-state cycle.
                            state_d   = ST_CLEAR;
                            wr_en_d   = 1'b1;
                            wr_addr_d = '0;
                            wr_data_d = INIT_VALUE;
                        end
                        default: ;
                    endcase
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
            end

            ST_CLEAR: begin
                // wr_addr_q doubles as the sweep counter; the last entry ends the sweep.
                if (wr_addr_q == LAST_ADDR) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                    addr_ptr_d   = '0;
                    lo_valid_d   = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + AWIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_ptr_q   <= '0;
            lo_q         <= '0;
            lo_valid_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_ptr_q   <= addr_ptr_d;
            lo_q         <= lo_d;
            lo_valid_q   <= lo_valid_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_addr   = wr_addr_q;
    assign busy          = busy_q;
    assign clear_done    = clear_done_q;
    assign seq_err       = seq_err_q;

`ifdef FF_LOADER_STATS_EN
    logic [31:0] wr_count_q, wr_count_d;

    // Counts issued strobes one cycle behind wr_en; saturates instead of wrapping.
    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_en_q && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`endif

`ifndef SYNTHESIS
    a_wr_en_only_when_busy: assert property (@(posedge clk) disable iff (rst)
        wr_en_q |-> busy_q);
    a_clear_done_idle: assert property (@(posedge clk) disable iff (rst)
        clear_done_q |-> ((state_q == ST_IDLE) && !wr_en_q));
`endif

endmodule

// File: tb/tb_first_filter_table_loader.sv
// Self-checking bench for first_filter_table_loader: directed vector table, CLEAR and
// reset corner sequences, then random commands against a word-level table-write model.
module tb_first_filter_table_loader;

    localparam int AW         = 13;
    localparam int DEPTH      = 8192;
    localparam int DW         = 64;
    localparam int WAIT_LIMIT = 20000;

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_LO  = 2'd1;
    localparam logic [1:0] OP_HI  = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    logic clk;
    logic rst;
    logic busy;
    logic clear_done;
    logic seq_err;
`ifdef FF_LOADER_STATS_EN
    logic [31:0] wr_count;
`endif

    first_filter_table_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    first_filter_table_loader #(
        .AWIDTH (AW),
        .DEPTH  (DEPTH),
        .DWIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .clear_done (clear_done),
        .seq_err    (seq_err)
`ifdef FF_LOADER_STATS_EN
        ,
        .wr_count   (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [31:0]   data;
        logic          exp_wr_en;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_seq_err;
    } vec_t;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } wr_rec_t;

    vec_t    vecs[18];
    wr_rec_t exp_q[$];
    wr_rec_t obs_q[$];
    bit      mon_on = 1'b0;
    int      n_checks = 0;
    int      n_fail = 0;
    longint  exp_wr_total = 0;

    always @(negedge clk) begin
        if (mon_on && bus.wr_en) begin
            obs_q.push_back('{addr: int'(bus.wr_addr), data: bus.wr_data});
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [1:0] op, input logic [31:0] data, output int waited);
        waited = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_op    = op;
        bus.cfg_data  = data;
        while (bus.cfg_ready !== 1'b1 && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= WAIT_LIMIT) begin
            check("send_ready_timeout", 64'(waited), 64'(WAIT_LIMIT - 1));
        end
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},      bus.wr_en,     0);
        check({tag, "_wr_addr"},    bus.wr_addr,   0);
        check({tag, "_wr_data"},    bus.wr_data,   0);
        check({tag, "_busy"},       busy,          0);
        check({tag, "_clear_done"}, clear_done,    0);
        check({tag, "_seq_err"},    seq_err,       0);
        check({tag, "_cfg_ready"},  bus.cfg_ready, 0);
    endtask

    task automatic check_wr_count(input string name);
`ifdef FF_LOADER_STATS_EN
        check(name, wr_count, 64'(exp_wr_total));
`else
        if (name.len() == 0) $display("wr_count check skipped");
`endif
    endtask

    task automatic run_clear();
        int waited;
        int wr_cnt = 0, addr_err = 0, data_err = 0, ready_err = 0;
        int done_cnt = 0, gaps = 0, last_wr = -1, done_at = -1;
        send(OP_CLR, 32'h0, waited);
        for (int c = 0; c < DEPTH + 16; c++) begin
            if (bus.wr_en === 1'b1) begin
                if (wr_cnt != 0 && last_wr != c - 1) gaps++;
                if (int'(bus.wr_addr) != wr_cnt) addr_err++;
                if (bus.wr_data !== {DW{1'b1}}) data_err++;
                wr_cnt++;
                last_wr = c;
            end
            if (clear_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (done_cnt == 0 && bus.cfg_ready !== 1'b0) ready_err++;
            @(negedge clk);
        end
        check("clr_write_count",   64'(wr_cnt),   64'(DEPTH));
        check("clr_addr_errors",   64'(addr_err), 0);
        check("clr_data_errors",   64'(data_err), 0);
        check("clr_gaps",          64'(gaps),     0);
        check("clr_ready_high",    64'(ready_err), 0);
        check("clr_done_pulses",   64'(done_cnt), 1);
        check("clr_done_position", 64'(done_at),  64'(last_wr + 1));
        check("clr_busy_after",    busy,          0);
        check("clr_ready_after",   bus.cfg_ready, 1);
        exp_wr_total += DEPTH;
    endtask

    initial begin
        int            waited;
        logic [1:0]    op;
        logic [31:0]   d;
        int            r;
        int            m_ptr;
        logic [31:0]   m_lo;
        bit            m_lo_valid;
        bit            m_seq_err;

        vecs[0]  = '{OP_SET, 32'hFFFF_1ABC, 1'b0, 13'h0000, 64'h0, 1'b0};
        vecs[1]  = '{OP_LO,  32'hDEAD_BEEF, 1'b0, 13'h0000, 64'h0, 1'b0};
        vecs[2]  = '{OP_HI,  32'hCAFE_F00D, 1'b1, 13'h1ABC, 64'hCAFE_F00D_DEAD_BEEF, 1'b0};
        vecs[3]  = '{OP_SET, 32'h0000_0005, 1'b0, 13'h1ABC, 64'hCAFE_F00D_DEAD_BEEF, 1'b0};
        vecs[4]  = '{OP_LO,  32'h89AB_CDEF, 1'b0, 13'h1ABC, 64'hCAFE_F00D_DEAD_BEEF, 1'b0};
        vecs[5]  = '{OP_HI,  32'h0123_4567, 1'b1, 13'h0005, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[6]  = '{OP_SET, 32'h0000_1FFF, 1'b0, 13'h0005, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[7]  = '{OP_LO,  32'h1111_1111, 1'b0, 13'h0005, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[8]  = '{OP_LO,  32'h2222_2222, 1'b0, 13'h0005, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[9]  = '{OP_HI,  32'h3333_3333, 1'b1, 13'h1FFF, 64'h3333_3333_2222_2222, 1'b0};
        vecs[10] = '{OP_LO,  32'h4444_4444, 1'b0, 13'h1FFF, 64'h3333_3333_2222_2222, 1'b0};
        vecs[11] = '{OP_HI,  32'h5555_5555, 1'b1, 13'h0000, 64'h5555_5555_4444_4444, 1'b0};
        vecs[12] = '{OP_HI,  32'h6666_6666, 1'b0, 13'h0000, 64'h5555_5555_4444_4444, 1'b1};
        vecs[13] = '{OP_LO,  32'h7777_7777, 1'b0, 13'h0000, 64'h5555_5555_4444_4444, 1'b1};
        vecs[14] = '{OP_HI,  32'h8888_8888, 1'b1, 13'h0001, 64'h8888_8888_7777_7777, 1'b1};
        vecs[15] = '{OP_LO,  32'h0000_0001, 1'b0, 13'h0001, 64'h8888_8888_7777_7777, 1'b1};
        vecs[16] = '{OP_SET, 32'h0000_0014, 1'b0, 13'h0001, 64'h8888_8888_7777_7777, 1'b1};
        vecs[17] = '{OP_HI,  32'h0000_0002, 1'b0, 13'h0001, 64'h8888_8888_7777_7777, 1'b1};

        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_op    = 2'd0;
        bus.cfg_data  = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus.cfg_ready, 1);
        check("busy_after_reset", busy, 0);
        check_wr_count("wr_count_reset");

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].data, waited);
            check($sformatf("vec%0d_wr_en", i),     bus.wr_en,     vecs[i].exp_wr_en);
            check($sformatf("vec%0d_wr_addr", i),   bus.wr_addr,   vecs[i].exp_addr);
            check($sformatf("vec%0d_wr_data", i),   bus.wr_data,   vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i),      busy,          vecs[i].exp_wr_en);
            check($sformatf("vec%0d_cfg_ready", i), bus.cfg_ready, !vecs[i].exp_wr_en);
            check($sformatf("vec%0d_seq_err", i),   seq_err,       vecs[i].exp_seq_err);
            if (vecs[i].exp_wr_en) exp_wr_total++;
        end

        // Back-to-back pairs: the command after a write must stall exactly one cycle.
        send(OP_SET, 32'd100, waited);
        send(OP_LO, 32'hA0A0_A0A0, waited);
        send(OP_HI, 32'hB0B0_B0B0, waited);
        check("rate_first_wr_en",   bus.wr_en,   1);
        check("rate_first_wr_addr", bus.wr_addr, 100);
        send(OP_LO, 32'hC0C0_C0C0, waited);
        check("rate_stall_cycles", 64'(waited), 1);
        check("rate_no_wr_on_lo",  bus.wr_en, 0);
        send(OP_HI, 32'hD0D0_D0D0, waited);
        check("rate_second_wr_en",   bus.wr_en,   1);
        check("rate_second_wr_addr", bus.wr_addr, 101);
        check("rate_second_wr_data", bus.wr_data, 64'hD0D0_D0D0_C0C0_C0C0);
        exp_wr_total += 2;
        @(negedge clk);
        check("rate_wr_en_single", bus.wr_en, 0);
        check("rate_data_hold",    bus.wr_data, 64'hD0D0_D0D0_C0C0_C0C0);

        // A pending DATA_LO must not survive CLEAR; the pointer restarts at 0.
        send(OP_LO, 32'hABCD_0000, waited);
        run_clear();
        send(OP_HI, 32'h0000_0001, waited);
        check("post_clr_hi_no_write", bus.wr_en, 0);
        send(OP_LO, 32'h0BAD_F00D, waited);
        send(OP_HI, 32'hFEED_0001, waited);
        check("post_clr_wr_en",   bus.wr_en,   1);
        check("post_clr_wr_addr", bus.wr_addr, 0);
        check("post_clr_wr_data", bus.wr_data, 64'hFEED_0001_0BAD_F00D);
        exp_wr_total++;
        repeat (2) @(negedge clk);
        check_wr_count("wr_count_after_clear");

        // Reset in the middle of a CLEAR sweep.
        send(OP_CLR, 32'h0, waited);
        repeat (100) @(negedge clk);
        check("rst_mid_clear_active", bus.wr_en, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_clear");
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        exp_wr_total = 0;
        @(negedge clk);
        check("rst_release_ready", bus.cfg_ready, 1);
        check("rst_release_busy",  busy,          0);
        check("rst_release_wr_en", bus.wr_en,     0);
        check_wr_count("wr_count_after_rst");

        // Random commands against a table-write model.
        m_ptr = 0;
        m_lo = 32'h0;
        m_lo_valid = 1'b0;
        m_seq_err = 1'b0;
        obs_q.delete();
        exp_q.delete();
        mon_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            d = $urandom;
            if (r < 2) begin
                op = OP_SET;
                if ($urandom_range(0, 2) == 0) d[12:0] = 13'(DEPTH - 1 - $urandom_range(0, 1));
                m_ptr = int'(d % 32'(DEPTH));
                m_lo_valid = 1'b0;
            end else if (r < 6) begin
                op = OP_LO;
                m_lo = d;
                m_lo_valid = 1'b1;
            end else begin
                op = OP_HI;
                if (m_lo_valid) begin
                    exp_q.push_back('{addr: m_ptr, data: {d, m_lo}});
                    m_ptr = (m_ptr + 1) % DEPTH;
                    m_lo_valid = 1'b0;
                end else begin
                    m_seq_err = 1'b1;
                end
            end
            send(op, d, waited);
            check($sformatf("rand%0d_seq_err", i), seq_err, m_seq_err);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        check("rand_write_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("rand_wr%0d_addr", i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check($sformatf("rand_wr%0d_data", i), obs_q[i].data, exp_q[i].data);
        end
        exp_wr_total += exp_q.size();
        check_wr_count("wr_count_after_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
